// File: rtl/vline_irq_ctrl_if.sv
// Scanline interrupt controller bus: video line counter and IRQ latch in,
// pending/overrun flags and encoded IPL out.
interface vline_irq_ctrl_if #(
  parameter int NCH = 2,
  parameter int VW  = 9
);
  logic [VW-1:0]  vcnt;
  logic [NCH-1:0] en;
  logic [NCH-1:0] ack;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] ovf;
  logic [2:0]     ipl;

  // video/CPU side that drives the controller
  modport master (
    output vcnt, en, ack,
    input  pending, ovf, ipl
  );

  // the controller itself
  modport slave (
    input  vcnt, en, ack,
    output pending, ovf, ipl
  );
endinterface

// File: rtl/vline_irq_ctrl.sv
// Parametrised scanline interrupt controller for the 68000 main-CPU board.
// Each channel pends when the line counter enters a line matching its masked
// compare pattern; pending channels are priority-encoded onto a 3-bit IPL.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_PRIME | first edge after reset: capture vcnt/en, no triggers or clears
// ST_RUN   | normal per-line trigger / clear / overrun tracking
module vline_irq_ctrl #(
  parameter int                 NCH   = 2,
  parameter int                 VW    = 9,
  parameter logic [NCH*VW-1:0]  MATCH = {9'h0E0, 9'h000},
  parameter logic [NCH*VW-1:0]  MASK  = {9'h1FF, 9'h13F}
) (
  input  logic            clk,
  input  logic            reset,
  vline_irq_ctrl_if.slave irq_if
);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [VW-1:0]  pv_q;
  logic [NCH-1:0] pen_q;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [2:0]     ipl_q, ipl_d;

  logic           line_new;
  logic [NCH-1:0] trig;
  logic [NCH-1:0] clr;

  // Per-channel trigger/clear resolution and IPL encode of the current flags
  always_comb begin
    state_d   = ST_RUN;
    line_new  = (state_q == ST_RUN) && (irq_if.vcnt != pv_q);
    trig      = '0;
    clr       = '0;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    ipl_d     = 3'd0;
    for (int c = 0; c < NCH; c++) begin
      trig[c] = line_new &&
                (((irq_if.vcnt ^ MATCH[c*VW +: VW]) & MASK[c*VW +: VW]) == '0);
      // the priming edge must not act on a stale previous-enable value or ack
      clr[c]  = (state_q == ST_RUN) &&
                (irq_if.ack[c] || (pen_q[c] && !irq_if.en[c]));
      if (trig[c] && irq_if.en[c]) begin
        // a fresh trigger beats a simultaneous clear; the clear only wipes ovf
        if (pending_q[c] && !clr[c]) begin
          ovf_d[c] = 1'b1;
        end
        pending_d[c] = 1'b1;
        if (clr[c]) begin
          ovf_d[c] = 1'b0;
        end
      end else if (clr[c]) begin
        pending_d[c] = 1'b0;
        ovf_d[c]     = 1'b0;
      end
      // ascending loop: highest pending channel wins
      if (pending_q[c]) begin
        ipl_d = 3'(c + 1);
      end
    end
  end

  // State, line/enable history and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_PRIME;
      pv_q      <= '0;
      pen_q     <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      ipl_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      pv_q      <= irq_if.vcnt;
      pen_q     <= irq_if.en;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      ipl_q     <= ipl_d;
    end
  end

  assign irq_if.pending = pending_q;
  assign irq_if.ovf     = ovf_q;
  assign irq_if.ipl     = ipl_q;

endmodule

// File: tb/tb_vline_irq_ctrl.sv
// Bench for vline_irq_ctrl: default 2-channel instance plus a 4-channel
// instance whose top channel matches every line.
module tb_vline_irq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  vline_irq_ctrl_if #(.NCH(2), .VW(9)) bus_a ();
  vline_irq_ctrl_if #(.NCH(4), .VW(9)) bus_b ();

  vline_irq_ctrl #(
    .NCH(2), .VW(9),
    .MATCH({9'h0E0, 9'h000}),
    .MASK ({9'h1FF, 9'h13F})
  ) dut_a (
    .clk(clk), .reset(reset), .irq_if(bus_a)
  );

  vline_irq_ctrl #(
    .NCH(4), .VW(9),
    .MATCH({9'h000, 9'h0A0, 9'h0E0, 9'h000}),
    .MASK ({9'h000, 9'h1FF, 9'h1FF, 9'h13F})
  ) dut_b (
    .clk(clk), .reset(reset), .irq_if(bus_b)
  );

  typedef struct {
    int         edge_n;
    int         id;
    bit         inst;
    logic [3:0] p;
    logic [3:0] o;
    logic [2:0] ipl;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   vec_id = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void check(input string name,
                                input logic [3:0] ap, input logic [3:0] ao, input logic [2:0] ai,
                                input logic [3:0] ep, input logic [3:0] eo, input logic [2:0] ei);
    n_vec++;
    if (ap !== ep || ao !== eo || ai !== ei) begin
      n_err++;
      $display("FAIL %s: got pending=%b ovf=%b ipl=%0d, expected pending=%b ovf=%b ipl=%0d",
               name, ap, ao, ai, ep, eo, ei);
    end
  endfunction

  // queue the expected outputs for the next rising edge (call at negedge)
  task automatic push_exp(input bit inst, input logic [3:0] p, input logic [3:0] o,
                          input logic [2:0] i);
    exp_t e;
    e.edge_n = edge_cnt + 1;
    e.id     = vec_id;
    e.inst   = inst;
    e.p      = p;
    e.o      = o;
    e.ipl    = i;
    vec_id++;
    sb.push_back(e);
  endtask

  task automatic step(input bit inst, input logic [8:0] v, input logic [3:0] e,
                      input logic [3:0] a, input bit chk,
                      input logic [3:0] p, input logic [3:0] o, input logic [2:0] i);
    @(negedge clk);
    if (inst) begin
      bus_b.vcnt = v;
      bus_b.en   = e;
      bus_b.ack  = a;
      bus_a.ack  = 2'b00;
    end else begin
      bus_a.vcnt = v;
      bus_a.en   = e[1:0];
      bus_a.ack  = a[1:0];
      bus_b.ack  = 4'b0000;
    end
    if (chk) push_exp(inst, p, o, i);
  endtask

  // monitor: compare every queued expectation on the edge it belongs to
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].edge_n <= edge_cnt) begin
        e = sb.pop_front();
        if (e.inst)
          check($sformatf("vec%0d", e.id), bus_b.pending, bus_b.ovf, bus_b.ipl,
                e.p, e.o, e.ipl);
        else
          check($sformatf("vec%0d", e.id), {2'b00, bus_a.pending}, {2'b00, bus_a.ovf},
                bus_a.ipl, e.p, e.o, e.ipl);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d expectations outstanding", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.vcnt = 9'd0; bus_a.en = 2'b00; bus_a.ack = 2'b00;
    bus_b.vcnt = 9'd0; bus_b.en = 4'b0000; bus_b.ack = 4'b0000;

    // reset state
    @(negedge clk);
    check("reset_a", {2'b00, bus_a.pending}, {2'b00, bus_a.ovf}, bus_a.ipl, 4'b0, 4'b0, 3'd0);
    check("reset_b", bus_b.pending, bus_b.ovf, bus_b.ipl, 4'b0, 4'b0, 3'd0);
    bus_a.en = 2'b11;
    reset = 1'b0;
    push_exp(0, 4'b0000, 4'b0000, 3'd0);               // priming edge
    step(0, 9'd0, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);

    // sweep lines 1..262 with all channels enabled
    for (int v = 1; v <= 262; v++) begin
      logic [3:0] a;
      logic [3:0] p;
      logic [2:0] i;
      bit         c;
      a = 4'b0000; p = 4'b0000; i = 3'd0; c = 1'b1;
      case (v)
        63:  ;
        64:  p = 4'b0001;
        65:  begin p = 4'b0001; i = 3'd1; end
        66:  begin a = 4'b0001; i = 3'd1; end
        67:  ;
        128: p = 4'b0001;
        129: begin p = 4'b0001; i = 3'd1; end
        130: begin a = 4'b0001; i = 3'd1; end
        131: ;
        192: p = 4'b0001;
        193: begin p = 4'b0001; i = 3'd1; end
        223: begin p = 4'b0001; i = 3'd1; end
        224: begin p = 4'b0011; i = 3'd1; end
        225: begin p = 4'b0011; i = 3'd2; end
        226: begin a = 4'b0011; i = 3'd2; end
        227: ;
        262: ;
        default: c = 1'b0;
      endcase
      step(0, 9'(v), 4'b0011, a, c, p, 4'b0000, i);
    end

    // wrap to line 0, then overrun by leaving ch0 un-acked into line 64
    step(0, 9'd0,  4'b0011, 4'b0000, 1, 4'b0001, 4'b0000, 3'd0);
    step(0, 9'd1,  4'b0011, 4'b0000, 1, 4'b0001, 4'b0000, 3'd1);
    step(0, 9'd64, 4'b0011, 4'b0000, 1, 4'b0001, 4'b0001, 3'd1);
    step(0, 9'd64, 4'b0011, 4'b0001, 1, 4'b0000, 4'b0000, 3'd1);
    step(0, 9'd64, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);

    // ch1 overrun, then ack colliding with a trigger on line 224
    step(0, 9'd224, 4'b0011, 4'b0000, 1, 4'b0010, 4'b0000, 3'd0);
    step(0, 9'd225, 4'b0011, 4'b0000, 1, 4'b0010, 4'b0000, 3'd2);
    step(0, 9'd224, 4'b0011, 4'b0000, 1, 4'b0010, 4'b0010, 3'd2);
    step(0, 9'd225, 4'b0011, 4'b0000, 1, 4'b0010, 4'b0010, 3'd2);
    step(0, 9'd224, 4'b0011, 4'b0010, 1, 4'b0010, 4'b0000, 3'd2);
    // holding a matching line never retriggers (would raise ovf)
    for (int k = 0; k < 10; k++)
      step(0, 9'd224, 4'b0011, 4'b0000, 1, 4'b0010, 4'b0000, 3'd2);
    step(0, 9'd224, 4'b0011, 4'b0010, 1, 4'b0000, 4'b0000, 3'd2);
    step(0, 9'd224, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);

    // enable drop clears, disabled channel ignores its line, no retroactive set
    step(0, 9'd0,  4'b0011, 4'b0000, 1, 4'b0001, 4'b0000, 3'd0);
    step(0, 9'd0,  4'b0011, 4'b0000, 1, 4'b0001, 4'b0000, 3'd1);
    step(0, 9'd0,  4'b0010, 4'b0000, 1, 4'b0000, 4'b0000, 3'd1);
    step(0, 9'd0,  4'b0010, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);
    step(0, 9'd64, 4'b0010, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);
    step(0, 9'd64, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);
    step(0, 9'd64, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);
    // trigger on the same edge as the enable falls: no set
    step(0, 9'd128, 4'b0010, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);
    step(0, 9'd128, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);

    // both pending, then asynchronous reset between edges
    step(0, 9'd192, 4'b0011, 4'b0000, 1, 4'b0001, 4'b0000, 3'd0);
    step(0, 9'd224, 4'b0011, 4'b0000, 1, 4'b0011, 4'b0000, 3'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check("async_reset", {2'b00, bus_a.pending}, {2'b00, bus_a.ovf}, bus_a.ipl,
             4'b0, 4'b0, 3'd0);
    @(negedge clk);
    bus_a.vcnt = 9'd0;
    bus_a.ack  = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    push_exp(0, 4'b0000, 4'b0000, 3'd0);
    step(0, 9'd0, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);
    step(0, 9'd1, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);

    // release with vcnt on a matching line that differs from the reset value
    @(negedge clk);
    reset = 1'b1;
    bus_a.vcnt = 9'd64;
    @(negedge clk);
    reset = 1'b0;
    push_exp(0, 4'b0000, 4'b0000, 3'd0);
    step(0, 9'd64, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);
    step(0, 9'd64, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 3'd0);

    // 4-channel instance: ch3 fires on every line change and owns ipl=4
    step(1, 9'd1,   4'b1111, 4'b0000, 1, 4'b1000, 4'b0000, 3'd0);
    step(1, 9'd2,   4'b1111, 4'b0000, 1, 4'b1000, 4'b1000, 3'd4);
    step(1, 9'd64,  4'b1111, 4'b0000, 1, 4'b1001, 4'b1000, 3'd4);
    step(1, 9'd65,  4'b1111, 4'b1000, 1, 4'b1001, 4'b0000, 3'd4);
    step(1, 9'd65,  4'b1111, 4'b1000, 1, 4'b0001, 4'b0000, 3'd4);
    step(1, 9'd65,  4'b1111, 4'b0000, 1, 4'b0001, 4'b0000, 3'd1);
    step(1, 9'd160, 4'b1111, 4'b0000, 1, 4'b1101, 4'b0000, 3'd1);
    step(1, 9'd160, 4'b1111, 4'b0000, 1, 4'b1101, 4'b0000, 3'd4);

    // let the monitor drain the scoreboard
    for (int k = 0; k < 5; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL drain vec%0d: expectation never compared, edge %0d now %0d",
               e.id, e.edge_n, edge_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
